frogger_scoreboard: RTL and testbench
=====================================

# frogger_scoreboard

Parametrised score, lives and game-state tracker for the Frogger game. It counts frog crossings as a BCD score and decrements a lives counter on each death. It detects the win and lose end conditions and drives all six seven-segment displays with the score, lives or an end-of-game message. It sits between the game-logic FSM (which issues `win`/`lose` events) and the board HEX outputs, and it supersedes the single-digit score counter.

## Interface
Parameters:
- `SCORE_DIGITS`, default 3: number of BCD score digits, legal range 1..4; shown on HEX[SCORE_DIGITS-1:0].
- `WIN_TARGET`, default 10: score at which the game is won, legal range 1..(10^SCORE_DIGITS − 1).
- `LIVES`, default 3: lives at game start, legal range 1..9.

Ports:
- `clock`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high; clock `clock`.
- `win`, input, 1: frog reached the far bank. Level input; the rising edge is the event.
- `lose`, input, 1: frog died. Level input; the rising edge is the event.
- `in`, input, 1: player restart button. Level input; the rising edge is the event.
- `game_over`, output, 1: high in WON or LOST.
- `won`, output, 1: high in WON only.
- `score_bcd`, output, 4*SCORE_DIGITS: current score, packed BCD, digit 0 in bits [3:0].
- `lives_left`, output, 4: remaining lives, binary.
- `HEX5`..`HEX0`, output, 7 each: active-low segments, bit order gfedcba.

## Operation
- Edge detection:
  - A 1-bit history register per input (`win`, `lose`, `in`).
  - Event = input high AND history low.
  - Reset sets all history registers to 1, so an input held high through reset produces no event.
  - Holding an input high produces exactly one event.
- States:
  - PLAY: reset state.
  - WON.
  - LOST.
- PLAY behaviour:
  - lose event: lives_left −1. If lives_left was 1, lives_left becomes 0 and the state goes to LOST; score is held.
  - win event (no lose event in the same cycle): score +1, BCD increment with decimal carry between digits. If the new score equals WIN_TARGET, the state goes to WON.
  - win and lose events in the same cycle: lose has priority; the win event is discarded (score unchanged).
  - in event: ignored.
- WON / LOST behaviour:
  - win and lose events: ignored.
  - in event: restart. score = 0, lives_left = LIVES, state = PLAY.
  - score_bcd and lives_left freeze at their end-of-game values until restart.
- Score never exceeds WIN_TARGET, so no wrap-around occurs. The increment must still wrap 9→0 with carry per digit.
- Segment codes:
  - Digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Letters: L=1000111, O=1000000, S=0010010, E=0000110, G=0000010, d=0100001.
  - blank = 1111111.
- Display in PLAY:
  - HEX5 = lives_left digit.
  - HEX4 = blank.
  - Score digits: leading zeros blanked; HEX0 always shows a digit.
  - HEX[3:SCORE_DIGITS] = blank.
- Display in LOST: HEX5..HEX0 = blank, blank, L, O, S, E.
- Display in WON: HEX5..HEX0 = blank, blank, G, O, O, d.

## Timing
- Reset values:
  - state PLAY, score_bcd 0, lives_left LIVES, game_over 0, won 0.
  - HEX5 = digit LIVES, HEX0 = "0", all other HEX blank.
  - History registers = 1.
- Latency: an input rising before clock edge k updates the state, score, lives and all outputs immediately after edge k (1 cycle). game_over, won and HEX are decoded from the registered state (no extra cycle).
- Minimum event spacing: an input must be low for at least 1 sampled cycle between events.
- `reset` overrides every event in the same cycle, including reset in the middle of WON, LOST or a score carry.
- Restart from WON/LOST takes effect on the same edge that detects the `in` rise. A `win` rise in that same cycle is ignored.

## Test plan
- Reset then idle, defaults → score_bcd 0x000, lives_left 3, HEX5=0110000, HEX2/HEX1 blank, HEX0=1000000, game_over 0.
- Hold `win` high 5 cycles → score 1 only. Then 8 more clean pulses → score 9, HEX0=0010000. 10th pulse → score 0x010 and WON: game_over 1, won 1, HEX3..HEX0 = G,O,O,d, all on the edge after the pulse.
- Three `lose` pulses → lives 2, 1, 0. After the third: LOST, HEX3..HEX0 = L,O,S,E, game_over 1, won 0. A further `win` pulse → no change.
- `win` and `lose` rise in the same cycle at score 4, lives 3 → score 4, lives 2.
- In LOST, `in` pulse → PLAY, score 0, lives 3, game_over 0. `in` pulse during PLAY → no change.
- SCORE_DIGITS=2, WIN_TARGET=12: 9 wins then 1 win → score_bcd 0x10, HEX1=1111001, HEX0=1000000. Assert reset during WON → all reset values the next cycle.

Source files
------------

// File: rtl/frogger_scoreboard.sv
// Frogger score/lives/game-state tracker with seven-segment drive; events are input rising edges.
// Single-cycle latency from an input rise to state and display; there is no backpressure.
module frogger_scoreboard #(
    parameter int SCORE_DIGITS = 3,
    parameter int WIN_TARGET   = 10,
    parameter int LIVES        = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      win,
    input  logic                      lose,
    input  logic                      in,
    output logic                      game_over,
    output logic                      won,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [3:0]                lives_left,
    output logic [6:0]                HEX5,
    output logic [6:0]                HEX4,
    output logic [6:0]                HEX3,
    output logic [6:0]                HEX2,
    output logic [6:0]                HEX1,
    output logic [6:0]                HEX0
);
    localparam int SW = 4 * SCORE_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_G     = 7'b0000010;
    localparam logic [6:0] SEG_D     = 7'b0100001;

    function automatic logic [SW-1:0] to_bcd(input int value);
        int rem;
        logic [SW-1:0] res;
        rem = value;
        res = '0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            res[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    localparam logic [SW-1:0] TARGET_BCD = to_bcd(WIN_TARGET);

    typedef enum logic [1:0] {PLAY, WON, LOST} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] score_q, score_d;
    logic [3:0]    lives_q, lives_d;
    logic          win_hist_q, lose_hist_q, in_hist_q;
    logic          win_ev, lose_ev, in_ev;
    logic [SW-1:0] score_inc;

    assign win_ev  = win  & ~win_hist_q;
    assign lose_ev = lose & ~lose_hist_q;
    assign in_ev   = in   & ~in_hist_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= PLAY;
            score_q     <= '0;
            lives_q     <= 4'(LIVES);
            win_hist_q  <= 1'b1;
            lose_hist_q <= 1'b1;
            in_hist_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            win_hist_q  <= win;
            lose_hist_q <= lose;
            in_hist_q   <= in;
        end
    end

    // Ripple BCD increment: each digit wraps 9->0 and passes the carry upward.
    always_comb begin
        logic carry;
        logic [3:0] dig;
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            dig = score_q[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        case (state_q)
            PLAY: begin
                if (lose_ev) begin
                    lives_d = lives_q - 4'd1;
                    if (lives_q == 4'd1) state_d = LOST;
                end else if (win_ev) begin
                    score_d = score_inc;
                    if (score_inc == TARGET_BCD) state_d = WON;
                end
            end
            WON, LOST: begin
                if (in_ev) begin
                    score_d = '0;
                    lives_d = 4'(LIVES);
                    state_d = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_comb begin
        logic [6:0] hex [0:5];
        logic       seen;
        logic [3:0] dig;
        for (int j = 0; j < 6; j++) hex[j] = SEG_BLANK;
        seen      = 1'b0;
        game_over = (state_q == WON) || (state_q == LOST);
        won       = (state_q == WON);
        case (state_q)
            WON: begin
                hex[3] = SEG_G; hex[2] = SEG_O; hex[1] = SEG_O; hex[0] = SEG_D;
            end
            LOST: begin
                hex[3] = SEG_L; hex[2] = SEG_O; hex[1] = SEG_S; hex[0] = SEG_E;
            end
            default: begin
                hex[5] = seg_digit(lives_q);
                // Scan from the most significant digit so leading zeros stay blank.
                for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
                    dig = score_q[4*i +: 4];
                    if (dig != 4'd0 || i == 0) seen = 1'b1;
                    if (seen) hex[i] = seg_digit(dig);
                end
            end
        endcase
        HEX0 = hex[0];
        HEX1 = hex[1];
        HEX2 = hex[2];
        HEX3 = hex[3];
        HEX4 = hex[4];
        HEX5 = hex[5];
    end

    assign score_bcd  = score_q;
    assign lives_left = lives_q;
endmodule

// File: tb/tb_frogger_scoreboard.sv
// Directed bench for frogger_scoreboard: default build (3 digits, target 10) and a
// 2-digit build (target 12) sharing one clock.
module tb_frogger_scoreboard;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] LG = 7'b0000010;
    localparam logic [6:0] LO = 7'b1000000;
    localparam logic [6:0] LD = 7'b0100001;
    localparam logic [6:0] LL = 7'b1000111;
    localparam logic [6:0] LS = 7'b0010010;
    localparam logic [6:0] LE = 7'b0000110;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic a_reset, a_win, a_lose, a_in;
    logic a_go, a_won;
    logic [11:0] a_score;
    logic [3:0]  a_lives;
    logic [6:0]  a_h5, a_h4, a_h3, a_h2, a_h1, a_h0;

    logic b_reset, b_win, b_lose, b_in;
    logic b_go, b_won;
    logic [7:0]  b_score;
    logic [3:0]  b_lives;
    logic [6:0]  b_h5, b_h4, b_h3, b_h2, b_h1, b_h0;

    frogger_scoreboard dut_a (
        .clock(clock), .reset(a_reset), .win(a_win), .lose(a_lose), .in(a_in),
        .game_over(a_go), .won(a_won), .score_bcd(a_score), .lives_left(a_lives),
        .HEX5(a_h5), .HEX4(a_h4), .HEX3(a_h3), .HEX2(a_h2), .HEX1(a_h1), .HEX0(a_h0)
    );

    frogger_scoreboard #(.SCORE_DIGITS(2), .WIN_TARGET(12), .LIVES(3)) dut_b (
        .clock(clock), .reset(b_reset), .win(b_win), .lose(b_lose), .in(b_in),
        .game_over(b_go), .won(b_won), .score_bcd(b_score), .lives_left(b_lives),
        .HEX5(b_h5), .HEX4(b_h4), .HEX3(b_h3), .HEX2(b_h2), .HEX1(b_h1), .HEX0(b_h0)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // which: 0 a_win, 1 a_lose, 2 a_in, 3 b_win
    task automatic pulse(input int which);
        case (which)
            0: a_win  = 1'b1;
            1: a_lose = 1'b1;
            2: a_in   = 1'b1;
            default: b_win = 1'b1;
        endcase
        step();
        a_win = 1'b0; a_lose = 1'b0; a_in = 1'b0; b_win = 1'b0;
        step();
    endtask

    initial begin
        a_reset = 1'b1; a_win = 1'b0; a_lose = 1'b0; a_in = 1'b0;
        b_reset = 1'b1; b_win = 1'b1; b_lose = 1'b0; b_in = 1'b0;
        step(); step();
        a_reset = 1'b0;
        step();
        check("rst_score", 32'(a_score), 32'h000);
        check("rst_lives", 32'(a_lives), 32'd3);
        check("rst_go",    32'(a_go),    32'd0);
        check("rst_won",   32'(a_won),   32'd0);
        check("rst_hex5",  32'(a_h5),    32'(D3));
        check("rst_hex4",  32'(a_h4),    32'(BL));
        check("rst_hex3",  32'(a_h3),    32'(BL));
        check("rst_hex2",  32'(a_h2),    32'(BL));
        check("rst_hex1",  32'(a_h1),    32'(BL));
        check("rst_hex0",  32'(a_h0),    32'(D0));

        a_win = 1'b1;
        step();
        check("first_edge_score", 32'(a_score), 32'h001);
        repeat (4) step();
        check("held_win_score", 32'(a_score), 32'h001);
        a_win = 1'b0;
        step();
        for (int i = 0; i < 8; i++) pulse(0);
        check("nine_score", 32'(a_score), 32'h009);
        check("nine_hex0",  32'(a_h0),    32'(D9));
        check("nine_hex1",  32'(a_h1),    32'(BL));
        check("nine_go",    32'(a_go),    32'd0);
        a_win = 1'b1;
        step();
        check("win_score", 32'(a_score), 32'h010);
        check("win_go",    32'(a_go),    32'd1);
        check("win_won",   32'(a_won),   32'd1);
        check("win_hex3",  32'(a_h3),    32'(LG));
        check("win_hex2",  32'(a_h2),    32'(LO));
        check("win_hex1",  32'(a_h1),    32'(LO));
        check("win_hex0",  32'(a_h0),    32'(LD));
        check("win_hex5",  32'(a_h5),    32'(BL));
        check("win_hex4",  32'(a_h4),    32'(BL));
        a_win = 1'b0;
        step();
        pulse(1);
        check("won_lose_ignored", 32'(a_lives), 32'd3);
        check("won_still_won",    32'(a_won),   32'd1);

        pulse(2);
        check("restart_score", 32'(a_score), 32'h000);
        check("restart_lives", 32'(a_lives), 32'd3);
        check("restart_go",    32'(a_go),    32'd0);

        for (int i = 0; i < 4; i++) pulse(0);
        check("four_score", 32'(a_score), 32'h004);
        check("four_hex0",  32'(a_h0),    32'(D4));
        a_win = 1'b1; a_lose = 1'b1;
        step();
        a_win = 1'b0; a_lose = 1'b0;
        check("both_score", 32'(a_score), 32'h004);
        check("both_lives", 32'(a_lives), 32'd2);
        check("both_hex5",  32'(a_h5),    32'(D2));
        step();
        pulse(1);
        check("lose2_lives", 32'(a_lives), 32'd1);
        check("lose2_go",    32'(a_go),    32'd0);
        check("lose2_hex5",  32'(a_h5),    32'(D1));
        a_lose = 1'b1;
        step();
        check("lost_lives", 32'(a_lives), 32'd0);
        check("lost_go",    32'(a_go),    32'd1);
        check("lost_won",   32'(a_won),   32'd0);
        check("lost_score", 32'(a_score), 32'h004);
        check("lost_hex3",  32'(a_h3),    32'(LL));
        check("lost_hex2",  32'(a_h2),    32'(LO));
        check("lost_hex1",  32'(a_h1),    32'(LS));
        check("lost_hex0",  32'(a_h0),    32'(LE));
        check("lost_hex5",  32'(a_h5),    32'(BL));
        a_lose = 1'b0;
        step();
        pulse(0);
        check("lost_win_ignored", 32'(a_score), 32'h004);
        check("lost_still_lost",  32'(a_go),    32'd1);
        pulse(2);
        check("relost_score", 32'(a_score), 32'h000);
        check("relost_lives", 32'(a_lives), 32'd3);
        check("relost_go",    32'(a_go),    32'd0);
        check("relost_hex5",  32'(a_h5),    32'(D3));
        pulse(2);
        check("play_in_score", 32'(a_score), 32'h000);
        check("play_in_lives", 32'(a_lives), 32'd3);
        check("play_in_go",    32'(a_go),    32'd0);

        // Second build: b_win stayed high through its reset and must not count.
        b_reset = 1'b0;
        step();
        check("b_held_win", 32'(b_score), 32'h00);
        b_win = 1'b0;
        step();
        for (int i = 0; i < 9; i++) pulse(3);
        check("b_nine", 32'(b_score), 32'h09);
        check("b_nine_hex1", 32'(b_h1), 32'(BL));
        pulse(3);
        check("b_ten",      32'(b_score), 32'h10);
        check("b_ten_hex1", 32'(b_h1),    32'(D1));
        check("b_ten_hex0", 32'(b_h0),    32'(D0));
        check("b_ten_hex2", 32'(b_h2),    32'(BL));
        check("b_ten_hex3", 32'(b_h3),    32'(BL));
        check("b_ten_go",   32'(b_go),    32'd0);
        pulse(3);
        pulse(3);
        check("b_win_score", 32'(b_score), 32'h12);
        check("b_win_won",   32'(b_won),   32'd1);
        check("b_win_hex0",  32'(b_h0),    32'(LD));
        b_reset = 1'b1; b_in = 1'b1;
        step();
        check("b_rst_score", 32'(b_score), 32'h00);
        check("b_rst_lives", 32'(b_lives), 32'd3);
        check("b_rst_go",    32'(b_go),    32'd0);
        check("b_rst_won",   32'(b_won),   32'd0);
        check("b_rst_hex5",  32'(b_h5),    32'(D3));
        check("b_rst_hex0",  32'(b_h0),    32'(D0));
        check("b_rst_hex1",  32'(b_h1),    32'(BL));
        b_reset = 1'b0;
        step();
        check("b_in_held_reset", 32'(b_go), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
